// File: rtl/cache_and_ram.sv
// Direct-mapped write-through cache over a word-addressed RAM model.
// Handles one load or store at a time through a level-sensitive request interface.
module cache_and_ram #(
   parameter int unsigned ADDR_BITS      = 12,
   parameter int unsigned LINES          = 16,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned RAM_LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inputAddress,
   input  logic [31:0] inputData,
   input  logic        loadEnable,
   input  logic        storeEnable,
   output logic [31:0] dataOut,
   output logic        storeCompleted,
   output logic        readyWire,
   output logic        validWire
);
   localparam int unsigned OFF_BITS   = $clog2(WORDS_PER_LINE);
   localparam int unsigned IDX_BITS   = $clog2(LINES);
   localparam int unsigned WADDR_BITS = ADDR_BITS - 2;
   localparam int unsigned TAG_BITS   = WADDR_BITS - IDX_BITS - OFF_BITS;
   localparam int unsigned RAM_WORDS  = 1 << WADDR_BITS;
   localparam int unsigned CNT_BITS   = $clog2(RAM_LATENCY + 1);
   localparam int unsigned LINE_BITS  = 32 * WORDS_PER_LINE;

   typedef enum logic [2:0] {StIdle, StLookup, StFill, StWrite, StDone} cacheState_e;

   cacheState_e           stateQ, stateD;
   logic [CNT_BITS-1:0]   cntQ, cntD;
   logic [WADDR_BITS-1:0] wordAddrQ;
   logic [31:0]           storeDataQ;
   logic [31:0]           dataOutQ;
   logic                  isLoadQ;
   logic [LINES-1:0]      validQ;

   logic [TAG_BITS-1:0]   tagMem  [LINES];
   logic [LINE_BITS-1:0]  lineMem [LINES];
   logic [31:0]           ramMem  [RAM_WORDS];
   logic [LINE_BITS-1:0]  ramLine;

   logic [OFF_BITS-1:0]            offset;
   logic [IDX_BITS-1:0]            index;
   logic [TAG_BITS-1:0]            tag;
   logic [WADDR_BITS-OFF_BITS-1:0] lineAddr;
   logic                           hit;
   logic                           lastCnt;
   logic                           accept;
   logic                           fillDone;
   logic                           writeCommit;
   logic                           storeHit;
   logic                           loadHit;
   logic                           unusedAddr;

   assign offset   = wordAddrQ[OFF_BITS-1:0];
   assign index    = wordAddrQ[OFF_BITS+IDX_BITS-1:OFF_BITS];
   assign tag      = wordAddrQ[WADDR_BITS-1:OFF_BITS+IDX_BITS];
   assign lineAddr = wordAddrQ[WADDR_BITS-1:OFF_BITS];
   assign hit      = validQ[index] && (tagMem[index] == tag);
   assign lastCnt  = (cntQ == CNT_BITS'(RAM_LATENCY - 1));
   assign accept   = (stateQ == StIdle) && (loadEnable || storeEnable);

   assign loadHit     = (stateQ == StLookup) && isLoadQ && hit;
   assign storeHit    = (stateQ == StLookup) && !isLoadQ && hit;
   assign fillDone    = (stateQ == StFill) && lastCnt;
   assign writeCommit = (stateQ == StWrite) && lastCnt;

   // High address bits alias and the byte offset is ignored.
   assign unusedAddr = ^{inputAddress[31:ADDR_BITS], inputAddress[1:0]};

   // RAM cells hold data XOR address, so an all-zero power-up array reads back as word w = w.
   always_comb begin
      ramLine = '0;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
         ramLine[32*w +: 32] = ramMem[{lineAddr, OFF_BITS'(w)}]
                               ^ 32'({lineAddr, OFF_BITS'(w)});
      end
   end

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (loadEnable || storeEnable) stateD = StLookup;
         end
         StLookup: begin
            cntD = '0;
            if (!isLoadQ)  stateD = StWrite;
            else if (hit)  stateD = StDone;
            else           stateD = StFill;
         end
         StFill, StWrite: begin
            if (lastCnt) stateD = StDone;
            else         cntD   = cntQ + 1'b1;
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ     <= StIdle;
         cntQ       <= '0;
         wordAddrQ  <= '0;
         storeDataQ <= '0;
         isLoadQ    <= 1'b0;
         validQ     <= '0;
         dataOutQ   <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (accept) begin
            wordAddrQ  <= inputAddress[ADDR_BITS-1:2];
            storeDataQ <= inputData;
            isLoadQ    <= loadEnable;
         end
         if (loadHit) dataOutQ <= lineMem[index][32*offset +: 32];
         if (fillDone) begin
            dataOutQ      <= ramLine[32*offset +: 32];
            validQ[index] <= 1'b1;
         end
      end
   end

   // Storage arrays carry no reset: RAM must survive reset and cache data is gated by validQ.
   always_ff @(posedge clk) begin
      if (fillDone) begin
         lineMem[index] <= ramLine;
         tagMem[index]  <= tag;
      end
      if (storeHit) lineMem[index][32*offset +: 32] <= storeDataQ;
      if (writeCommit) ramMem[wordAddrQ] <= storeDataQ ^ 32'(wordAddrQ);
   end

   assign dataOut        = dataOutQ;
   assign readyWire      = (stateQ == StIdle);
   assign validWire      = (stateQ == StDone) && isLoadQ;
   assign storeCompleted = (stateQ == StDone) && !isLoadQ;

endmodule

// File: tb/tb_cache_and_ram.sv
// Scoreboard bench for cache_and_ram: a small cache/RAM model predicts data and latency
// at each accepted request; the monitor checks every completion pulse against it.
module tb_cache_and_ram;
   localparam int RamLatency = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inputAddress = '0;
   logic [31:0] inputData = '0;
   logic        loadEnable = 1'b0;
   logic        storeEnable = 1'b0;
   logic [31:0] dataOut;
   logic        storeCompleted;
   logic        readyWire;
   logic        validWire;

   cache_and_ram #(
      .ADDR_BITS     (12),
      .LINES         (16),
      .WORDS_PER_LINE(4),
      .RAM_LATENCY   (RamLatency)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .inputAddress  (inputAddress),
      .inputData     (inputData),
      .loadEnable    (loadEnable),
      .storeEnable   (storeEnable),
      .dataOut       (dataOut),
      .storeCompleted(storeCompleted),
      .readyWire     (readyWire),
      .validWire     (validWire)
   );

   always #25 clk = ~clk;

   typedef struct {
      logic        isLoad;
      logic [9:0]  word;
      logic [31:0] data;
      int          expLat;
      int          acc;
   } sbEntry_t;

   sbEntry_t    sbQ[$];
   logic [31:0] ramModel [1024];
   logic [15:0] mValid;
   logic [3:0]  mTag [16];
   logic [31:0] holdData = '0;
   int          cycle = 0;
   int          doneCount = 0;
   int          compareCount = 0;
   int          mismatchCount = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Predict the outcome of a request the DUT is about to accept.
   task automatic modelAccept();
      sbEntry_t    e;
      logic [9:0]  w;
      logic        mHit;
      w      = inputAddress[11:2];
      mHit   = mValid[w[5:2]] && (mTag[w[5:2]] == w[9:6]);
      e.isLoad = loadEnable;
      e.word   = w;
      e.acc    = cycle;
      if (loadEnable) begin
         e.data   = ramModel[w];
         e.expLat = mHit ? 2 : 2 + RamLatency;
         mValid[w[5:2]] = 1'b1;
         mTag[w[5:2]]   = w[9:6];
      end else begin
         e.data   = inputData;
         e.expLat = 2 + RamLatency;
      end
      sbQ.push_back(e);
   endtask

   always @(negedge clk) begin
      sbEntry_t e;
      cycle++;
      if (rst_n) begin
         checkVal("ready", readyWire, (sbQ.size() == 0));
         if (!validWire) checkVal("dataHold", dataOut, holdData);
         if (validWire || storeCompleted) begin
            if (sbQ.size() == 0) begin
               checkVal("unexpectedPulse", {validWire, storeCompleted}, 0);
            end else begin
               e = sbQ.pop_front();
               checkVal("pulseKind", validWire, e.isLoad);
               checkVal("latency", cycle - e.acc, e.expLat);
               if (e.isLoad) begin
                  checkVal("loadData", dataOut, e.data);
                  holdData = e.data;
               end else begin
                  ramModel[e.word] = e.data;
               end
               doneCount++;
            end
         end else if (sbQ.size() != 0 && (cycle - sbQ[0].acc) > 12) begin
            checkVal("pulseTimeout", cycle - sbQ[0].acc, sbQ[0].expLat);
            void'(sbQ.pop_front());
         end
         if (readyWire && (loadEnable || storeEnable)) modelAccept();
      end
   end

   task automatic clearModelForReset();
      sbQ.delete();
      mValid   = '0;
      holdData = '0;
   endtask

   task automatic waitIdle();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (readyWire) break;
      end
   endtask

   // Hold a request until n completions have been observed, then drop it.
   task automatic doReq(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] data, input int n);
      int start;
      int k;
      waitIdle();
      @(posedge clk);
      #5;
      inputAddress = addr;
      inputData    = data;
      loadEnable   = ld;
      storeEnable  = st;
      start        = doneCount;
      k            = 0;
      while ((doneCount - start) < n && k < 200) begin
         @(posedge clk);
         k++;
      end
      #5;
      loadEnable  = 1'b0;
      storeEnable = 1'b0;
      checkVal("reqCount", doneCount - start, n);
   endtask

   task automatic applyReset();
      @(posedge clk);
      #5;
      rst_n       = 1'b0;
      loadEnable  = 1'b0;
      storeEnable = 1'b0;
      clearModelForReset();
      #1;
      checkVal("rstReady", readyWire, 1);
      checkVal("rstValid", validWire, 0);
      checkVal("rstStore", storeCompleted, 0);
      checkVal("rstData", dataOut, 0);
      @(posedge clk);
      #5;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      for (int w = 0; w < 1024; w++) ramModel[w] = w;
      mValid = '0;
      #10;
      checkVal("porReady", readyWire, 1);
      checkVal("porValid", validWire, 0);
      checkVal("porStore", storeCompleted, 0);
      checkVal("porData", dataOut, 0);
      @(posedge clk);
      #5;
      rst_n = 1'b1;

      doReq(1, 0, 32'd0, 0, 3);            // miss, then two re-hits
      doReq(1, 0, 32'd12, 0, 1);           // same line, hit
      doReq(1, 0, 32'd64, 0, 1);           // index 4 miss
      doReq(1, 0, 32'd0, 0, 1);            // index 0 still resident
      doReq(1, 0, 32'd256, 0, 1);          // conflict evicts index 0
      doReq(1, 0, 32'd0, 0, 1);            // miss again
      doReq(0, 1, 32'd0, 32'h38C0, 2);     // store, held: rewrites same data
      doReq(1, 0, 32'd0, 0, 1);
      applyReset();
      doReq(1, 0, 32'd0, 0, 1);            // RAM persisted across reset
      doReq(1, 1, 32'd4, 32'hDEAD_BEEF, 1); // load wins
      applyReset();
      doReq(1, 0, 32'd4, 0, 1);            // RAM word 1 untouched

      // Reset while the store sits in WRITE before its commit cycle.
      waitIdle();
      @(posedge clk);
      #5;
      inputAddress = 32'd8;
      inputData    = 32'h1234_5678;
      storeEnable  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #5;
      rst_n       = 1'b0;
      storeEnable = 1'b0;
      clearModelForReset();
      #1;
      checkVal("abortReady", readyWire, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkVal("abortNoStore", storeCompleted, 0);
      end
      @(posedge clk);
      #5;
      rst_n = 1'b1;
      doReq(1, 0, 32'd8, 0, 1);

      // Random mix over two indices and four tags to exercise conflicts.
      for (int i = 0; i < 24; i++) begin
         a = {20'h0, 4'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 4'd4 : 4'd0,
              2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 2) == 0) doReq(0, 1, a, $urandom, 1);
         else                           doReq(1, 0, a | 32'hABC0_0000, 0, 1);
      end

      waitIdle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

   initial begin
      #(50 * 20000);
      $display("FAIL watchdog: simulation did not finish, compared %0d", compareCount);
      $fatal(1);
   end

endmodule
